vio_scan_chain: RTL and testbench
=================================

VIO_SCAN_CHAIN -- requirements
Module: vio_scan_chain

Interface
REQ-001 Parameter N_LED, 36, number of virtual LED inputs captured into the chain.
REQ-002 Parameter N_SSD, 8, number of 8-bit seven-segment digit inputs captured into the chain.
REQ-003 Parameter N_SW, 36, number of virtual switch outputs driven from the chain.
REQ-004 Parameter N_BTN, 20, number of virtual button outputs driven from the chain.
REQ-005 Parameter BTN_PULSE, 0, button mode: 0 = level, 1 = one-CLOCK pulse per 0->1 update.
REQ-006 Parameter SW_INIT, all zeros (N_SW bits), switch value after reset and after test-logic reset.
REQ-007 CLOCK  input  1  sole clock, all state rising-edge; reset is asynchronous and active-high.
REQ-008 RESET  input  1  asynchronous, active-high reset.
REQ-009 JTCK / JTMS / JTDI  input  1 each  raw debug pins, asynchronous to CLOCK.
REQ-010 JTDO  output  1  serial data out, registered.
REQ-011 iLED  input  N_LED  live LED state; iSSLED  input  8*N_SSD  digits packed, digit 0 at LSBs.
REQ-012 oSW  output  N_SW  switch values; oBTN  output  N_BTN  button values.
REQ-013 oUPDATE  output  1  one-CLOCK strobe in the cycle oSW/oBTN load.

Function
REQ-014 JTCK/JTMS/JTDI SHALL each pass a 2-flop synchronizer; a third JTCK flop SHALL provide edge detection.
REQ-015 A synchronized JTCK rising edge (rise) SHALL act on synchronized JTMS/JTDI; action visible 3 CLOCK cycles after the pin edge; CLOCK >= 4x JTCK required.
REQ-016 Chain length L = N_LED + 8*N_SSD + N_SW + N_BTN; shift register SR[L-1:0], bit 0 nearest JTDO.
REQ-017 SR field order LSB->MSB: LED, SSD, SW, BTN.
REQ-018 States: TLR, IDLE, CAPTURE, SHIFT, UPDATE; transitions only on rise.
REQ-019 TLR: JTMS=0 -> IDLE, else stay.
REQ-020 IDLE: JTMS=1 -> CAPTURE, else stay.
REQ-021 CAPTURE: SR <= {oBTN_level, oSW, iSSLED, iLED}; JTMS=0 -> SHIFT, JTMS=1 -> UPDATE.
REQ-022 SHIFT: SR <= {JTDI, SR[L-1:1]}; JTMS=0 stay, JTMS=1 -> UPDATE (the shift still occurs on that rise).
REQ-023 UPDATE entry: oSW <= SR SW field, button level register <= SR BTN field, oUPDATE pulses; JTMS=0 -> IDLE, 1 -> CAPTURE.
REQ-024 A saturating counter of consecutive rises with JTMS=1 SHALL force TLR on the 5th, from any state, overriding REQ-019..023.
REQ-025 Entering TLR SHALL set oSW <= SW_INIT and button level to 0; SR unchanged.
REQ-026 JTDO SHALL register SR[0] on each synchronized JTCK falling edge, hold otherwise.
REQ-027 BTN_PULSE=0: oBTN = button level register. BTN_PULSE=1: oBTN bit high for exactly the one CLOCK after a 0->1 level change, else 0.
REQ-028 Rise with no edge in progress and no state change: SR, oSW, oBTN SHALL hold.
REQ-029 Glitches shorter than 2 CLOCK periods on JTCK are not required to be filtered; no extra edges SHALL be generated by the synchronizer.

Reset
REQ-030 RESET SHALL clear synchronizers, SR, JTDO, oUPDATE, edge flop and TMS counter to 0, set state TLR, oSW to SW_INIT, oBTN to 0.
REQ-031 RESET asserted mid-shift SHALL abort the scan; no partial update of oSW/oBTN.

Verification
REQ-032 Reset, then 5 JTCK with JTMS=1 -> state TLR, oSW=SW_INIT, oBTN=0, JTDO=0.
REQ-033 N_LED=4,N_SSD=1,N_SW=4,N_BTN=4 (L=20): iLED=4'hA, iSSLED=8'h3C, capture then 20 shifts -> JTDO emits 0,1,0,1,0,0,1,1,1,1,0,0, then 8 zeros.
REQ-034 Same config: shift in 20 bits with SW field 4'h9, BTN field 4'h5, then UPDATE -> oSW=4'h9, oBTN=4'h5, oUPDATE high exactly 1 CLOCK.
REQ-035 BTN_PULSE=1: update BTN=4'h1 twice consecutively -> oBTN[0] high 1 CLOCK after first update only; after update to 0 then 1 -> pulses again.
REQ-036 RESET pulsed during SHIFT after 10 bits -> oSW=SW_INIT, state TLR, no oUPDATE pulse.
REQ-037 JTCK at CLOCK/4 with JTMS held high from SHIFT -> UPDATE on 1st rise, TLR forced on 5th rise, oSW=SW_INIT.

Source files
------------

// File: rtl/vio_scan_chain.sv
`default_nettype none
// ============================================================================
// vio_scan_chain : JTAG-style virtual LED/SSD capture and switch/button drive
// Revision       : 1.0
// ============================================================================
module vio_scan_chain #(
  parameter int              N_LED     = 36,
  parameter int              N_SSD     = 8,
  parameter int              N_SW      = 36,
  parameter int              N_BTN     = 20,
  parameter int              BTN_PULSE = 0,
  parameter logic [N_SW-1:0] SW_INIT   = '0
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               JTCK,
  input  logic               JTMS,
  input  logic               JTDI,
  output logic               JTDO,
  input  logic [N_LED-1:0]   iLED,
  input  logic [8*N_SSD-1:0] iSSLED,
  output logic [N_SW-1:0]    oSW,
  output logic [N_BTN-1:0]   oBTN,
  output logic               oUPDATE
);

  localparam int c_LEN     = N_LED + 8*N_SSD + N_SW + N_BTN;
  localparam int c_SW_LSB  = N_LED + 8*N_SSD;
  localparam int c_BTN_LSB = c_SW_LSB + N_SW;

  localparam logic [2:0] c_ST_TLR     = 3'd0;
  localparam logic [2:0] c_ST_IDLE    = 3'd1;
  localparam logic [2:0] c_ST_CAPTURE = 3'd2;
  localparam logic [2:0] c_ST_SHIFT   = 3'd3;
  localparam logic [2:0] c_ST_UPDATE  = 3'd4;

  // jtck_q[2] is the edge-detect flop behind the two synchronizer stages
  logic [2:0]       jtck_q;
  logic [1:0]       jtms_q;
  logic [1:0]       jtdi_q;
  logic [2:0]       state_q,   state_d;
  logic [2:0]       tms_cnt_q, tms_cnt_d;
  logic [c_LEN-1:0] sr_q,      sr_d;
  logic [N_SW-1:0]  sw_q,      sw_d;
  logic [N_BTN-1:0] btn_lvl_q, btn_lvl_d;
  logic             upd_q,     upd_d;
  logic             jtdo_q;

  logic w_rise;
  logic w_fall;
  logic w_tms;
  logic w_tdi;

  assign w_rise = jtck_q[1] & ~jtck_q[2];
  assign w_fall = ~jtck_q[1] & jtck_q[2];
  assign w_tms  = jtms_q[1];
  assign w_tdi  = jtdi_q[1];

  always_comb begin
    state_d   = state_q;
    tms_cnt_d = tms_cnt_q;
    sr_d      = sr_q;
    sw_d      = sw_q;
    btn_lvl_d = btn_lvl_q;
    upd_d     = 1'b0;
    if (w_rise) begin
      case (state_q)
        c_ST_TLR:     if (!w_tms) state_d = c_ST_IDLE;
        c_ST_IDLE:    if (w_tms)  state_d = c_ST_CAPTURE;
        c_ST_CAPTURE: begin
          sr_d    = {btn_lvl_q, sw_q, iSSLED, iLED};
          state_d = w_tms ? c_ST_UPDATE : c_ST_SHIFT;
        end
        c_ST_SHIFT: begin
          sr_d = {w_tdi, sr_q[c_LEN-1:1]};
          if (w_tms) state_d = c_ST_UPDATE;
        end
        c_ST_UPDATE:  state_d = w_tms ? c_ST_CAPTURE : c_ST_IDLE;
        default:      state_d = c_ST_TLR;
      endcase

      // Fifth consecutive TMS-high rise wins over every other transition
      if (w_tms) begin
        if (tms_cnt_q != 3'd5) tms_cnt_d = tms_cnt_q + 3'd1;
        if (tms_cnt_q >= 3'd4) state_d = c_ST_TLR;
      end else begin
        tms_cnt_d = 3'd0;
      end

      // Update loads the post-shift value so the final TDI bit lands in place
      if (state_d == c_ST_TLR) begin
        sw_d      = SW_INIT;
        btn_lvl_d = '0;
      end else if (state_d == c_ST_UPDATE) begin
        sw_d      = sr_d[c_SW_LSB +: N_SW];
        btn_lvl_d = sr_d[c_BTN_LSB +: N_BTN];
        upd_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      jtck_q    <= '0;
      jtms_q    <= '0;
      jtdi_q    <= '0;
      state_q   <= c_ST_TLR;
      tms_cnt_q <= '0;
      sr_q      <= '0;
      sw_q      <= SW_INIT;
      btn_lvl_q <= '0;
      upd_q     <= 1'b0;
      jtdo_q    <= 1'b0;
    end else begin
      jtck_q    <= {jtck_q[1:0], JTCK};
      jtms_q    <= {jtms_q[0], JTMS};
      jtdi_q    <= {jtdi_q[0], JTDI};
      state_q   <= state_d;
      tms_cnt_q <= tms_cnt_d;
      sr_q      <= sr_d;
      sw_q      <= sw_d;
      btn_lvl_q <= btn_lvl_d;
      upd_q     <= upd_d;
      if (w_fall) jtdo_q <= sr_q[0];
    end
  end

  generate
    if (BTN_PULSE != 0) begin : g_btn_pulse
      logic [N_BTN-1:0] btn_prev_q;
      always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) btn_prev_q <= '0;
        else       btn_prev_q <= btn_lvl_q;
      end
      assign oBTN = btn_lvl_q & ~btn_prev_q;
    end else begin : g_btn_level
      assign oBTN = btn_lvl_q;
    end
  endgenerate

  assign oSW     = sw_q;
  assign oUPDATE = upd_q;
  assign JTDO    = jtdo_q;

endmodule
`default_nettype wire

// File: tb/tb_vio_scan_chain.sv
`default_nettype none
// ============================================================================
// tb_vio_scan_chain : scan transactions on level and pulse-button instances
// Revision          : 1.0
// ============================================================================
module tb_vio_scan_chain;

  localparam logic [3:0] c_INIT_A = 4'h0;
  localparam logic [3:0] c_INIT_B = 4'hC;

  logic       CLOCK;
  logic       RESET;
  logic       JTCK;
  logic       JTMS;
  logic       JTDI;
  logic [3:0] iLED;
  logic [7:0] iSSLED;
  logic       jtdo_a, jtdo_b, upd_a, upd_b;
  logic [3:0] sw_a, sw_b, btn_a, btn_b;

  vio_scan_chain #(.N_LED(4), .N_SSD(1), .N_SW(4), .N_BTN(4),
                   .BTN_PULSE(0), .SW_INIT(c_INIT_A)) dut_a (
    .CLOCK(CLOCK), .RESET(RESET), .JTCK(JTCK), .JTMS(JTMS), .JTDI(JTDI),
    .JTDO(jtdo_a), .iLED(iLED), .iSSLED(iSSLED), .oSW(sw_a), .oBTN(btn_a),
    .oUPDATE(upd_a));

  vio_scan_chain #(.N_LED(4), .N_SSD(1), .N_SW(4), .N_BTN(4),
                   .BTN_PULSE(1), .SW_INIT(c_INIT_B)) dut_b (
    .CLOCK(CLOCK), .RESET(RESET), .JTCK(JTCK), .JTMS(JTMS), .JTDI(JTDI),
    .JTDO(jtdo_b), .iLED(iLED), .iSSLED(iSSLED), .oSW(sw_b), .oBTN(btn_b),
    .oUPDATE(upd_b));

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Strobe and pulse widths are measured by counting high CLOCK samples
  int upd_cnt_a = 0;
  int upd_cnt_b = 0;
  int pulse_cnt [4] = '{default: 0};
  always @(negedge CLOCK) begin
    if (upd_a === 1'b1) upd_cnt_a++;
    if (upd_b === 1'b1) upd_cnt_b++;
    for (int b = 0; b < 4; b++) if (btn_b[b] === 1'b1) pulse_cnt[b]++;
  end

  // Transaction-level model: what software believes the virtual I/O holds
  logic [3:0] m_sw_a, m_sw_b, m_btn;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    repeat (4) @(negedge CLOCK);
  endtask

  task automatic tck(input logic tms, input logic tdi, input int half,
                     output logic tdo_a, output logic tdo_b);
    JTMS = tms;
    JTDI = tdi;
    repeat (half) @(negedge CLOCK);
    tdo_a = jtdo_a;
    tdo_b = jtdo_b;
    JTCK = 1'b1;
    repeat (half) @(negedge CLOCK);
    JTCK = 1'b0;
  endtask

  task automatic tck_n(input logic tms, input logic tdi);
    logic da, db;
    tck(tms, tdi, 4, da, db);
  endtask

  // Full data-register scan from IDLE back to IDLE, LSB of din shifted first
  task automatic scan(input logic [19:0] din, output logic [19:0] dout_a);
    logic [19:0] da, db, exp_a, exp_b;
    logic        ta, tb;
    logic [3:0]  new_btn;
    int          ua, ub;
    int          pc [4];
    exp_a   = {m_btn, m_sw_a, iSSLED, iLED};
    exp_b   = {m_btn, m_sw_b, iSSLED, iLED};
    new_btn = din[19:16];
    ua = upd_cnt_a;
    ub = upd_cnt_b;
    pc = pulse_cnt;
    tck_n(1'b1, 1'b0);
    tck_n(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tck((i == 19), din[i], 4, ta, tb);
      da[i] = ta;
      db[i] = tb;
    end
    tck_n(1'b0, 1'b0);
    settle();
    check("scan_out_a", da, exp_a);
    check("scan_out_b", db, exp_b);
    check("upd_once_a", upd_cnt_a - ua, 1);
    check("upd_once_b", upd_cnt_b - ub, 1);
    for (int b = 0; b < 4; b++)
      check("btn_pulse_b", pulse_cnt[b] - pc[b], (new_btn[b] && !m_btn[b]) ? 1 : 0);
    m_sw_a = din[15:12];
    m_sw_b = din[15:12];
    m_btn  = new_btn;
    check("sw_a", sw_a, m_sw_a);
    check("sw_b", sw_b, m_sw_b);
    check("btn_a", btn_a, m_btn);
    check("btn_b_idle", btn_b, 4'h0);
    dout_a = da;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [19:0] dout;
    logic [19:0] din;
    logic [3:0]  btn_seq [5];
    int          ua, ub;
    int          pc [4];

    RESET = 1'b1; JTCK = 1'b0; JTMS = 1'b0; JTDI = 1'b0;
    iLED = 4'h0; iSSLED = 8'h00;
    repeat (3) @(negedge CLOCK);
    RESET = 1'b0;
    @(negedge CLOCK);
    m_sw_a = c_INIT_A; m_sw_b = c_INIT_B; m_btn = 4'h0;
    check("rst_sw_a", sw_a, c_INIT_A);
    check("rst_sw_b", sw_b, c_INIT_B);
    check("rst_btn_a", btn_a, 4'h0);
    check("rst_btn_b", btn_b, 4'h0);
    check("rst_jtdo", {jtdo_b, jtdo_a}, 2'b00);
    check("rst_upd", {upd_b, upd_a}, 2'b00);

    // Five TMS-high clocks park the chain in test-logic reset
    for (int i = 0; i < 5; i++) tck_n(1'b1, 1'b0);
    settle();
    check("tlr_sw_b", sw_b, c_INIT_B);
    check("tlr_btn", {btn_b, btn_a}, 8'h00);
    check("tlr_jtdo", jtdo_a, 1'b0);
    tck_n(1'b0, 1'b0);

    // Directed capture of LED=A / SSD=3C while loading SW=9, BTN=5
    iLED = 4'hA; iSSLED = 8'h3C;
    din = {4'h5, 4'h9, 12'($urandom)};
    scan(din, dout);
    check("capture_literal", dout, 20'h003CA);
    check("sw_literal", sw_a, 4'h9);
    check("btn_literal", btn_a, 4'h5);

    // Repeated identical button values must pulse only on a 0->1 change
    btn_seq = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h1};
    for (int k = 0; k < 5; k++) begin
      din = {btn_seq[k], 16'($urandom)};
      scan(din, dout);
    end

    for (int k = 0; k < 6; k++) begin
      iLED   = 4'($urandom);
      iSSLED = 8'($urandom);
      din    = 20'($urandom);
      scan(din, dout);
    end

    // CAPTURE straight to UPDATE reloads the same switch/button values
    ua = upd_cnt_a;
    pc = pulse_cnt;
    tck_n(1'b1, 1'b0);
    tck_n(1'b1, 1'b0);
    tck_n(1'b0, 1'b0);
    settle();
    check("cap_upd_strobe", upd_cnt_a - ua, 1);
    check("cap_upd_sw", sw_a, m_sw_a);
    check("cap_upd_btn", btn_a, m_btn);
    check("cap_upd_nopulse", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]
                             - pc[0] - pc[1] - pc[2] - pc[3], 0);

    // RESET in the middle of a shift discards the partial scan
    din = {4'hF, 4'h9, 12'($urandom)};
    scan(din, dout);
    ua = upd_cnt_a;
    ub = upd_cnt_b;
    tck_n(1'b1, 1'b0);
    tck_n(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tck_n(1'b0, 1'($urandom));
    RESET = 1'b1;
    repeat (2) @(negedge CLOCK);
    RESET = 1'b0;
    settle();
    m_sw_a = c_INIT_A; m_sw_b = c_INIT_B; m_btn = 4'h0;
    check("abort_sw_a", sw_a, c_INIT_A);
    check("abort_sw_b", sw_b, c_INIT_B);
    check("abort_btn", {btn_b, btn_a}, 8'h00);
    check("abort_jtdo", jtdo_a, 1'b0);
    check("abort_no_upd", (upd_cnt_a - ua) + (upd_cnt_b - ub), 0);

    // TMS held high from SHIFT at CLOCK/4: update, then forced reset on rise 5
    tck_n(1'b0, 1'b0);
    tck_n(1'b1, 1'b0);
    tck_n(1'b0, 1'b0);
    din = 20'($urandom);
    for (int i = 0; i < 19; i++) tck_n(1'b0, din[i]);
    ua = upd_cnt_a;
    pc = pulse_cnt;
    begin
      logic da, db;
      tck(1'b1, din[19], 2, da, db);
      repeat (2) @(negedge CLOCK);
      check("fast_upd_sw_a", sw_a, din[15:12]);
      check("fast_upd_sw_b", sw_b, din[15:12]);
      check("fast_upd_btn_a", btn_a, din[19:16]);
      for (int i = 0; i < 4; i++) tck(1'b1, 1'b0, 2, da, db);
    end
    settle();
    check("fast_tlr_sw_a", sw_a, c_INIT_A);
    check("fast_tlr_sw_b", sw_b, c_INIT_B);
    check("fast_tlr_btn_a", btn_a, 4'h0);
    check("fast_upd_count", upd_cnt_a - ua, 2);
    for (int b = 0; b < 4; b++)
      check("fast_btn_pulse", pulse_cnt[b] - pc[b], din[16 + b] ? 1 : 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
